// File: rtl/mov_branch_unit_if.sv
// rtl/mov_branch_unit_if.sv - decode-side bus of the mov/branch unit
// Purpose: groups instruction, flag, pc, pin and register-file write signals.
// Modports:
//   slave  - the mov_branch_unit itself (takes instruction, drives pc/write port/pins)
//   master - the decode/register-file side (drives instruction, observes results)
interface mov_branch_unit_if #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2
);
  logic                    enable;
  logic [2*REG_ADDR_W-1:0] addrs;
  logic [DATA_W-1:0]       src_data;
  logic [DATA_W-1:0]       offset;
  logic                    carry_flag;
  logic                    borrow_flag;
  logic [DATA_W-1:0]       pc;
  logic                    wr_en;
  logic [REG_ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    branch_taken;
  logic                    out_sel;
  logic [DATA_W-1:0]       pins_out;

  modport slave (
    input  enable, addrs, src_data, offset, carry_flag, borrow_flag,
    output pc, wr_en, wr_addr, wr_data, branch_taken, out_sel, pins_out
  );

  modport master (
    output enable, addrs, src_data, offset, carry_flag, borrow_flag,
    input  pc, wr_en, wr_addr, wr_data, branch_taken, out_sel, pins_out
  );
endinterface

// File: rtl/mov_branch_unit.sv
// rtl/mov_branch_unit.sv - clocked register-move / branch / pin-toggle unit
// Purpose: executes one MOV, branch or out_sel toggle per enabled cycle and owns
//          the program counter, pin source select and a registered write port.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mov_branch_unit_if.slave (instruction/flags in; pc, write port,
//          branch pulse, out_sel and pins_out out)
// Configuration macro: MOVBR_LINK_EN - taken branches also write old pc + 1
//          into register 0 through the write port.
// Parameters must match those of the connected interface instance.
module mov_branch_unit #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mov_branch_unit_if.slave     bus
);

  logic [DATA_W-1:0]     r_pc;
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0]     r_wr_data;
  logic                  r_branch_taken;
  logic                  r_out_sel;

  logic [REG_ADDR_W-1:0] w_res_addr;
  logic [REG_ADDR_W-1:0] w_src_addr;
  logic                  w_is_mov;
  logic                  w_is_special;
  logic [1:0]            w_op;
  logic                  w_take;
  logic                  w_toggle;
  logic [DATA_W-1:0]     w_pc_inc;
  logic [DATA_W-1:0]     w_pc_br;

  assign w_res_addr = bus.addrs[2*REG_ADDR_W-1:REG_ADDR_W];
  assign w_src_addr = bus.addrs[REG_ADDR_W-1:0];
  assign w_is_mov   = (w_res_addr != w_src_addr);
  // Shifting out the two op bits keeps this legal when REG_ADDR_W == 2.
  assign w_is_special = !w_is_mov && ((w_src_addr >> 2) == '0);
  assign w_op         = w_src_addr[1:0];

  assign w_take   = w_is_special &&
                    ((w_op == 2'd0) ||
                     ((w_op == 2'd1) && bus.carry_flag) ||
                     ((w_op == 2'd2) && bus.borrow_flag));
  assign w_toggle = w_is_special && (w_op == 2'd3);

  // Natural wrap of the adders gives modulo-2^DATA_W, two's-complement offsets.
  assign w_pc_inc = r_pc + DATA_W'(1);
  assign w_pc_br  = r_pc + bus.offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_branch_taken <= 1'b0;
      r_out_sel      <= 1'b0;
    end else begin
      r_wr_en        <= 1'b0;
      r_branch_taken <= 1'b0;
      if (bus.enable) begin
        if (w_is_mov) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_res_addr;
          r_wr_data <= bus.src_data;
          r_pc      <= w_pc_inc;
        end else if (w_take) begin
          r_pc           <= w_pc_br;
          r_branch_taken <= 1'b1;
`ifdef MOVBR_LINK_EN
          r_wr_en   <= 1'b1;
          r_wr_addr <= '0;
          r_wr_data <= w_pc_inc;
`endif
        end else begin
          // Untaken branch, toggle and NOP all just step the pc.
          r_pc <= w_pc_inc;
          if (w_toggle) begin
            r_out_sel <= ~r_out_sel;
          end
        end
      end
    end
  end

  assign bus.pc           = r_pc;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.branch_taken = r_branch_taken;
  assign bus.out_sel      = r_out_sel;
  assign bus.pins_out     = r_out_sel ? r_pc : bus.offset;

endmodule

// File: tb/tb_mov_branch_unit.sv
// tb/tb_mov_branch_unit.sv - self-checking bench for mov_branch_unit
module tb_mov_branch_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mov_branch_unit_if #(.DATA_W(8), .REG_ADDR_W(2)) bus ();

  mov_branch_unit #(.DATA_W(8), .REG_ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state
  int m_pc, m_wr_en, m_wr_addr, m_wr_data, m_bt, m_out_sel;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int rs, input int en, input int a, input int sd,
                       input int off, input int c, input int b);
    int res, src;
    bit take;
    if (rs != 0) begin
      m_pc = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_bt = 0; m_out_sel = 0;
      return;
    end
    m_wr_en = 0;
    m_bt    = 0;
    if (en == 0) return;
    res  = a / 4;
    src  = a % 4;
    take = 0;
    if (res != src) begin
      m_wr_en = 1; m_wr_addr = res; m_wr_data = sd;
      m_pc = (m_pc + 1) % 256;
      return;
    end
    if (src == 0) take = 1;
    else if (src == 1) take = (c != 0);
    else if (src == 2) take = (b != 0);
    if (take) begin
`ifdef MOVBR_LINK_EN
      m_wr_en = 1; m_wr_addr = 0; m_wr_data = (m_pc + 1) % 256;
`endif
      m_pc = (m_pc + off) % 256;
      m_bt = 1;
    end else begin
      if (src == 3) m_out_sel = 1 - m_out_sel;
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      int'(bus.pc),           m_pc);
    chk({tag, ".wr_en"},   int'(bus.wr_en),        m_wr_en);
    chk({tag, ".wr_addr"}, int'(bus.wr_addr),      m_wr_addr);
    chk({tag, ".wr_data"}, int'(bus.wr_data),      m_wr_data);
    chk({tag, ".bt"},      int'(bus.branch_taken), m_bt);
    chk({tag, ".out_sel"}, int'(bus.out_sel),      m_out_sel);
    chk({tag, ".pins"},    int'(bus.pins_out),
        (m_out_sel != 0) ? m_pc : int'(bus.offset));
  endtask

  task automatic step(input string tag, input int rs, input int en, input int a,
                      input int sd, input int off, input int c, input int b);
    rst             = rs[0];
    bus.enable      = en[0];
    bus.addrs       = 4'(a);
    bus.src_data    = 8'(sd);
    bus.offset      = 8'(off);
    bus.carry_flag  = c[0];
    bus.borrow_flag = b[0];
    model(rs, en, a, sd, off, c, b);
    @(posedge clk);
    #1;
    // Flags toggled away from the sampling edge must not matter.
    bus.carry_flag  = ~bus.carry_flag;
    bus.borrow_flag = ~bus.borrow_flag;
    check_all(tag);
  endtask

  initial begin
    int off;
    rst = 1'b1;
    bus.enable = 1'b0; bus.addrs = '0; bus.src_data = '0; bus.offset = '0;
    bus.carry_flag = 1'b0; bus.borrow_flag = 1'b0;
    m_pc = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_bt = 0; m_out_sel = 0;

    step("reset", 1, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", int'(bus.pc), 0);

    step("mov", 0, 1, 'b1001, 'h5A, 0, 0, 0);
    chk("mov_wr_en", int'(bus.wr_en), 1);
    chk("mov_wr_addr", int'(bus.wr_addr), 2);
    chk("mov_wr_data", int'(bus.wr_data), 'h5A);
    chk("mov_pc", int'(bus.pc), 1);
    step("idle", 0, 0, 'b1001, 'h33, 0, 0, 0);
    chk("idle_wr_en", int'(bus.wr_en), 0);
    chk("idle_wr_data_hold", int'(bus.wr_data), 'h5A);

    step("to10", 0, 1, 'b0000, 0, 'h0F, 0, 0);
    step("carry_taken", 0, 1, 'b0101, 0, 'h20, 1, 0);
    chk("carry_taken_pc", int'(bus.pc), 'h30);
    chk("carry_taken_bt", int'(bus.branch_taken), 1);
    step("carry_not", 0, 1, 'b0101, 0, 'h20, 0, 0);
    chk("carry_not_pc", int'(bus.pc), 'h31);
    chk("carry_not_bt", int'(bus.branch_taken), 0);
    step("borrow_not", 0, 1, 'b1010, 0, 'h40, 1, 0);
    step("borrow_taken", 0, 1, 'b1010, 0, 'h40, 0, 1);

    off = (3 - m_pc) & 'hFF;
    step("to03", 0, 1, 'b0000, 0, off, 0, 0);
    step("back2", 0, 1, 'b0000, 0, 'hFE, 0, 0);
    chk("back2_pc", int'(bus.pc), 1);
    step("toFF", 0, 1, 'b0000, 0, 'hFE, 0, 0);
    step("wrap", 0, 1, 'b0110, 'h11, 0, 0, 0);
    chk("wrap_pc", int'(bus.pc), 0);
    step("zero_off", 0, 1, 'b0000, 0, 0, 0, 0);
    chk("zero_off_bt", int'(bus.branch_taken), 1);

    step("to44", 0, 1, 'b0000, 0, 'h44, 0, 0);
    step("tog1", 0, 1, 'b1111, 0, 'h99, 0, 0);
    chk("tog1_pins", int'(bus.pins_out), 'h45);
    step("tog2", 0, 1, 'b1111, 0, 'h99, 0, 0);
    chk("tog2_pins", int'(bus.pins_out), 'h99);

    step("rst_en", 1, 1, 'b1010, 0, 'h77, 0, 1);
    chk("rst_en_bt", int'(bus.branch_taken), 0);

`ifdef MOVBR_LINK_EN
    step("to07", 0, 1, 'b0000, 0, 7, 0, 0);
    step("link", 0, 1, 'b0000, 0, 8, 0, 0);
    chk("link_pc", int'(bus.pc), 'h0F);
    chk("link_wr_addr", int'(bus.wr_addr), 0);
    chk("link_wr_data", int'(bus.wr_data), 8);
`endif

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 40) == 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)));
      bus.offset = 8'($urandom_range(0, 255));
      #1;
      chk("rand_pins_live", int'(bus.pins_out),
          (m_out_sel != 0) ? m_pc : int'(bus.offset));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mov_branch_unit.md
# mov_branch_unit

Parametrised successor to the CPU's mov/branch decode. It executes one register-move or branch/toggle instruction per enabled cycle and owns the program counter. It also owns the output-pin source select and a registered register-file write port. It sits between instruction decode and the register file / pin mux, replacing the purely combinational mov/branch decode with a clocked unit.

## Interface
- `DATA_W`, default 8: datapath, program counter and offset width.
- `REG_ADDR_W`, default 2: register address width; the instruction field is 2*REG_ADDR_W bits, and REG_ADDR_W must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `enable` in 1: instruction valid this cycle.
- `addrs` in 2*REG_ADDR_W: `[2*REG_ADDR_W-1:REG_ADDR_W]` is the result register; `[REG_ADDR_W-1:0]` is the source register.
- `src_data` in DATA_W: contents of the source register.
- `offset` in DATA_W: contents of the branch register (r3); added to pc on a taken branch.
- `carry_flag` in 1: ALU carry flag.
- `borrow_flag` in 1: ALU borrow flag.
- `pc` out DATA_W: program counter.
- `wr_en` out 1: register-file write strobe.
- `wr_addr` out REG_ADDR_W: write address.
- `wr_data` out DATA_W: write data.
- `branch_taken` out 1: one-cycle pulse after a taken branch.
- `out_sel` out 1: pin source select; 0 = offset, 1 = pc.
- `pins_out` out DATA_W: `out_sel ? pc : offset` (combinational).

## Operation
Decode happens when `enable`=1 at a rising edge.
- Addresses differ: MOV. Next cycle `wr_en`=1, `wr_addr`=result address, `wr_data`=`src_data`; `pc` += 1.
- Addresses equal, upper REG_ADDR_W-2 bits of the address zero, low two bits select the special op:
  - 00: unconditional branch.
  - 01: branch if `carry_flag`.
  - 10: branch if `borrow_flag`.
  - 11: toggle `out_sel`; `pc` += 1.
- Addresses equal, upper bits non-zero: NOP; `pc` += 1.
- Branch taken: `pc` += `offset`, and `branch_taken`=1 for one cycle.
- Branch not taken: `pc` += 1, and `branch_taken` stays 0.
- `enable`=0: all state holds; `wr_en` and `branch_taken` return to 0.

Arithmetic rules:
- All pc arithmetic is modulo 2^DATA_W. `offset` is effectively two's complement, so 0xFF on 8 bits moves pc back by 1.
- Wrap from 0xFF to 0x00 is legal and silent.
- `offset`=0 on a taken branch leaves pc unchanged and still pulses `branch_taken`.

Flag and write-port rules:
- Flags are sampled in the same edge as the instruction; flag changes in other cycles have no effect.
- `wr_en`, `wr_addr` and `wr_data` are registered and valid for exactly one cycle per MOV.
- `wr_addr` and `wr_data` hold their last values when `wr_en`=0.

## Timing
Reset values:
- When `rst`=1 at an edge: `pc`=0, `out_sel`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `branch_taken`=0.
- `rst` overrides `enable` in the same cycle; the instruction is dropped.
- Reset mid-stream discards any instruction presented in that cycle.

Latency:
- One cycle for every registered output.
- The instruction at edge N is reflected in outputs after edge N.
- `pins_out` follows `out_sel`/`pc` combinationally and follows the live `offset` input.

Throughput:
- One instruction per cycle; back-to-back branches each apply to the pc already updated by the previous edge.
- A toggle updates `out_sel` once per enabled toggle instruction; consecutive toggles alternate it.

## Configuration
- `MOVBR_LINK_EN` defined: on a taken branch, the unit also writes the return address (old pc + 1, modulo 2^DATA_W) into register 0. Next cycle `wr_en`=1, `wr_addr`=0, `wr_data`=old pc + 1.
- Not defined: branches never assert `wr_en`.
- No conflict arises in either build, because a branch is never a MOV.

## Test plan
- Reset, then MOV with `addrs`=0b1001, `src_data`=0x5A → next cycle `wr_en`=1, `wr_addr`=2, `wr_data`=0x5A, `pc`=1; the following idle cycle gives `wr_en`=0.
- pc=0x10, `addrs`=0b0101, `carry_flag`=1, `offset`=0x20 → `pc`=0x30 and `branch_taken`=1 for one cycle. Same with `carry_flag`=0 → `pc`=0x11 and `branch_taken`=0.
- pc=0x03, `addrs`=0b0000, `offset`=0xFE → `pc`=0x01. pc=0xFF with a MOV → `pc`=0x00.
- `addrs`=0b1111 twice with pc=0x44, `offset`=0x99 → `out_sel` goes 1 then 0; `pins_out` reads 0x45 (pc after the first toggle), then 0x99.
- `enable`=1 and `rst`=1 together, with `addrs`=0b1010 (borrow branch, `borrow_flag`=1) → all outputs 0 and no branch pulse.
- With `MOVBR_LINK_EN`: pc=0x07, taken unconditional branch, `offset`=0x08 → `pc`=0x0F, `wr_en`=1, `wr_addr`=0, `wr_data`=0x08.
